// File: rtl/im_loader.sv
// im_loader: writer side of the instruction memory. It takes a byte stream over
// a valid/ready handshake, packs four bytes big-endian into a 32-bit word and
// writes the words one after another into IM, starting at BASE_ADDR.
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             In_Valid,
    input  logic [7:0]       In_Byte,
    input  logic             In_Last,
    output logic             In_Ready,
    output logic             IM_WE,
    output logic [31:0]      IM_Addr,
    output logic [31:0]      IM_WD,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] Word_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      word_buf, word_buf_nxt;
    logic [1:0]       byte_cnt, byte_cnt_nxt;
    logic             last_flag, last_flag_nxt;
    logic             we, we_nxt;
    logic [31:0]      addr, addr_nxt;
    logic [31:0]      wd, wd_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [CNT_W-1:0] word_cnt_inc;
    logic             done, done_nxt;
    logic             err, err_nxt;
    logic             accept;

    // Start takes priority, so no byte is taken in the cycle of a restart.
    assign In_Ready     = (state == S_RECV) && !Start;
    assign accept       = In_Valid && In_Ready;
    assign word_cnt_inc = word_cnt + CNT_W'(1);

    assign IM_WE    = we;
    assign IM_Addr  = addr;
    assign IM_WD    = wd;
    assign Busy     = (state == S_RECV) || (state == S_WRITE);
    assign Done     = done;
    assign Err      = err;
    assign Word_Cnt = word_cnt;

    // Next-state and next-register values. The write strobe is a one-cycle
    // pulse that is raised only on entry to WRITE.
    always_comb begin
        state_nxt     = state;
        word_buf_nxt  = word_buf;
        byte_cnt_nxt  = byte_cnt;
        last_flag_nxt = last_flag;
        we_nxt        = 1'b0;
        addr_nxt      = addr;
        wd_nxt        = wd;
        word_cnt_nxt  = word_cnt;
        done_nxt      = done;
        err_nxt       = err;
        if (Start) begin
            // A restart drops any partial word. A strobe that is already
            // active finishes in the current cycle.
            state_nxt    = S_RECV;
            byte_cnt_nxt = 2'd0;
            word_cnt_nxt = '0;
            done_nxt     = 1'b0;
            err_nxt      = 1'b0;
            addr_nxt     = BASE_ADDR;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_RECV: begin
                    if (accept) begin
                        word_buf_nxt = {word_buf[23:0], In_Byte};
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state_nxt     = S_WRITE;
                            last_flag_nxt = In_Last;
                            we_nxt        = 1'b1;
                            wd_nxt        = {word_buf[23:0], In_Byte};
                        end else if (In_Last) begin
                            // The image ended partway through a word. The
                            // partial word is not written.
                            state_nxt = S_ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = S_RECV;
                        end
                    end else begin
                        state_nxt = S_RECV;
                    end
                end
                S_WRITE: begin
                    addr_nxt     = addr + 32'd4;
                    word_cnt_nxt = word_cnt_inc;
                    if (last_flag) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else if (word_cnt_inc == CNT_W'(DEPTH)) begin
                        // IM is full and the image has not ended.
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_RECV;
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                S_ERR: begin
                    state_nxt = S_ERR;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset clears all of them immediately, so no
    // strobe is issued after reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            word_buf  <= 32'h0000_0000;
            byte_cnt  <= 2'd0;
            last_flag <= 1'b0;
            we        <= 1'b0;
            addr      <= BASE_ADDR;
            wd        <= 32'h0000_0000;
            word_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_buf  <= word_buf_nxt;
            byte_cnt  <= byte_cnt_nxt;
            last_flag <= last_flag_nxt;
            we        <= we_nxt;
            addr      <= addr_nxt;
            wd        <= wd_nxt;
            word_cnt  <= word_cnt_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader. Instance a uses the default depth. Instance b uses
// DEPTH=4 to reach the overflow case.
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, valid_a, last_a;
    logic [7:0]  byte_a;
    logic        ready_a, we_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, wd_a;
    logic [10:0] wc_a;

    logic        start_b, valid_b, last_b;
    logic [7:0]  byte_b;
    logic        ready_b, we_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, wd_b;
    logic [2:0]  wc_b;

    im_loader dut_a (
        .Clk(clk), .Rst(rst_n), .Start(start_a), .In_Valid(valid_a),
        .In_Byte(byte_a), .In_Last(last_a), .In_Ready(ready_a), .IM_WE(we_a),
        .IM_Addr(addr_a), .IM_WD(wd_a), .Busy(busy_a), .Done(done_a),
        .Err(err_a), .Word_Cnt(wc_a)
    );

    im_loader #(.BASE_ADDR(32'h0000_3000), .DEPTH(4), .CNT_W(3)) dut_b (
        .Clk(clk), .Rst(rst_n), .Start(start_b), .In_Valid(valid_b),
        .In_Byte(byte_b), .In_Last(last_b), .In_Ready(ready_b), .IM_WE(we_b),
        .IM_Addr(addr_b), .IM_WD(wd_b), .Busy(busy_b), .Done(done_b),
        .Err(err_b), .Word_Cnt(wc_b)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int we_cnt_a = 0;
    int we_cnt_b = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare each write strobe against the next expected {addr, data}.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            we_cnt_a++;
            if (exp_a.size() == 0) check_val("unexpected_we_a", {addr_a, wd_a}, 64'd0);
            else check_val("im_write_a", {addr_a, wd_a}, exp_a.pop_front());
        end
        if (we_b === 1'b1) begin
            we_cnt_b++;
            if (exp_b.size() == 0) check_val("unexpected_we_b", {addr_b, wd_b}, 64'd0);
            else check_val("im_write_b", {addr_b, wd_b}, exp_b.pop_front());
        end
    end

    // Every task below starts and ends 1 time unit after a rising edge.
    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit last, input int gap);
        bit got;
        repeat (gap) begin @(posedge clk); #1; end
        if (sel) begin valid_b = 1'b1; byte_b = b; last_b = last; end
        else begin valid_a = 1'b1; byte_a = b; last_a = last; end
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if ((sel ? ready_b : ready_a) === 1'b1) got = 1'b1;
            @(posedge clk); #1;
        end
        valid_a = 1'b0; last_a = 1'b0;
        valid_b = 1'b0; last_b = 1'b0;
        if (!got) check_val("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input bit last, input int gap);
        send_byte(sel, w[31:24], 1'b0, gap);
        send_byte(sel, w[23:16], 1'b0, gap);
        send_byte(sel, w[15:8], 1'b0, gap);
        send_byte(sel, w[7:0], last, gap);
    endtask

    task automatic two_word_load(input int gap);
        int base;
        pulse_start(1'b0);
        base = we_cnt_a;
        exp_a.push_back({BASE, 32'h1234_5678});
        exp_a.push_back({BASE + 32'd4, 32'h9ABC_DEF0});
        send_word(1'b0, 32'h1234_5678, 1'b0, gap);
        send_word(1'b0, 32'h9ABC_DEF0, 1'b1, gap);
        repeat (3) begin @(posedge clk); #1; end
        check_val("two_word_done", 64'(done_a), 64'd1);
        check_val("two_word_err", 64'(err_a), 64'd0);
        check_val("two_word_cnt", 64'(wc_a), 64'd2);
        check_val("two_word_busy", 64'(busy_a), 64'd0);
        check_val("two_word_we_count", 64'(we_cnt_a - base), 64'd2);
        check_val("two_word_queue_empty", 64'(exp_a.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        start_a = 1'b0; valid_a = 1'b0; last_a = 1'b0; byte_a = 8'h00;
        start_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; byte_b = 8'h00;
        repeat (2) begin @(posedge clk); #1; end

        // Reset state
        check_val("rst_we", 64'(we_a), 64'd0);
        check_val("rst_addr", 64'(addr_a), 64'(BASE));
        check_val("rst_wd", 64'(wd_a), 64'd0);
        check_val("rst_word_cnt", 64'(wc_a), 64'd0);
        check_val("rst_done", 64'(done_a), 64'd0);
        check_val("rst_err", 64'(err_a), 64'd0);
        check_val("rst_ready", 64'(ready_a), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("idle_ready", 64'(ready_a), 64'd0);

        // Back-to-back bytes, then the same stream with 3-cycle gaps
        two_word_load(0);
        two_word_load(3);

        // The image ends partway through the first word
        pulse_start(1'b0);
        base = we_cnt_a;
        send_byte(1'b0, 8'hAA, 1'b0, 0);
        send_byte(1'b0, 8'hBB, 1'b0, 0);
        send_byte(1'b0, 8'hCC, 1'b1, 0);
        repeat (2) begin @(posedge clk); #1; end
        check_val("short_err", 64'(err_a), 64'd1);
        check_val("short_done", 64'(done_a), 64'd0);
        check_val("short_word_cnt", 64'(wc_a), 64'd0);
        check_val("short_we_count", 64'(we_cnt_a - base), 64'd0);
        check_val("short_ready", 64'(ready_a), 64'd0);

        // Overflow with DEPTH=4
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_b.push_back({BASE + 32'(4 * k), 32'hA0B0_C0D0 + 32'(k) * 32'h0101_0101});
        end
        for (int k = 0; k < 4; k++) begin
            send_word(1'b1, 32'hA0B0_C0D0 + 32'(k) * 32'h0101_0101, 1'b0, 0);
        end
        repeat (2) begin @(posedge clk); #1; end
        check_val("ovf_err", 64'(err_b), 64'd1);
        check_val("ovf_done", 64'(done_b), 64'd0);
        check_val("ovf_ready", 64'(ready_b), 64'd0);
        check_val("ovf_word_cnt", 64'(wc_b), 64'd4);
        check_val("ovf_addr", 64'(addr_b), 64'(BASE + 32'd16));
        valid_b = 1'b1; byte_b = 8'h55;
        repeat (5) begin @(posedge clk); #1; end
        valid_b = 1'b0;
        check_val("ovf_we_count", 64'(we_cnt_b), 64'd4);
        check_val("ovf_queue_empty", 64'(exp_b.size()), 64'd0);

        // Restart in the middle of the second word
        pulse_start(1'b0);
        exp_a.push_back({BASE, 32'h0102_0304});
        send_word(1'b0, 32'h0102_0304, 1'b0, 0);
        send_byte(1'b0, 8'h05, 1'b0, 0);
        send_byte(1'b0, 8'h06, 1'b0, 0);
        pulse_start(1'b0);
        check_val("restart_word_cnt", 64'(wc_a), 64'd0);
        check_val("restart_addr", 64'(addr_a), 64'(BASE));
        base = we_cnt_a;
        exp_a.push_back({BASE, 32'h1122_3344});
        send_word(1'b0, 32'h1122_3344, 1'b1, 0);
        repeat (3) begin @(posedge clk); #1; end
        check_val("restart_done", 64'(done_a), 64'd1);
        check_val("restart_word_cnt_end", 64'(wc_a), 64'd1);
        check_val("restart_we_count", 64'(we_cnt_a - base), 64'd1);
        check_val("restart_queue_empty", 64'(exp_a.size()), 64'd0);

        // Reset asserted in the middle of a load
        pulse_start(1'b0);
        send_byte(1'b0, 8'h77, 1'b0, 0);
        send_byte(1'b0, 8'h88, 1'b0, 0);
        base = we_cnt_a;
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_we", 64'(we_a), 64'd0);
        check_val("midrst_busy", 64'(busy_a), 64'd0);
        check_val("midrst_ready", 64'(ready_a), 64'd0);
        check_val("midrst_addr", 64'(addr_a), 64'(BASE));
        check_val("midrst_word_cnt", 64'(wc_a), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check_val("midrst_no_we", 64'(we_cnt_a - base), 64'd0);
        check_val("midrst_idle_busy", 64'(busy_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
